// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART transmitter with a byte FIFO in front of the line.
// Optional even parity bit when UART_TX_PARITY_EN is defined (8E1 framing).
//
// Ports:
//   iFpgaClk    system clock, rising edge
//   iFpgaRstN   async active-low reset
//   iTxData     byte to queue, sampled on the push edge
//   iTxValid    push request, accepted when oTxReady is high
//   oTxReady    FIFO not full
//   oUartTx     serial line, idle high, registered
//   oBusy       frame on the line or bytes queued
//   oFifoCount  bytes currently queued (0..FIFO_DEPTH)
module uart_tx_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic             iFpgaClk,
    input  logic             iFpgaRstN,
    input  logic [7:0]       iTxData,
    input  logic             iTxValid,
    output logic             oTxReady,
    output logic             oUartTx,
    output logic             oBusy,
    output logic [FIFO_AW:0] oFifoCount
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    state_t             state;
    logic [BAUD_W-1:0]  baud;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               tx;

    logic               baud_end;
    logic               push;
    logic               pop;

    assign baud_end = (baud == BAUD_LAST);
    assign push     = iTxValid && (count != FULL_CNT);
    // The FSM pops either from idle or at the end of a stop bit,
    // which lets back-to-back frames run with no idle gap.
    assign pop      = (count != '0) &&
                      ((state == ST_IDLE) ||
                       ((state == ST_STOP) && baud_end));

    assign oTxReady   = (count != FULL_CNT);
    assign oUartTx    = tx;
    assign oBusy      = (state != ST_IDLE) || (count != '0);
    assign oFifoCount = count;

    // Storage is not reset; validity is tracked by the count.
    always_ff @(posedge iFpgaClk) begin
        if (push) begin
            mem[wr_ptr] <= iTxData;
        end
    end

    always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
        if (!iFpgaRstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
        if (!iFpgaRstN) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        baud  <= '0;
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= ^shift;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    baud  <= '0;
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed bench for uart_tx_unit with a line monitor
// that decodes frames and compares them against a byte scoreboard.
module tb_uart_tx_unit;

    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic          clk;
    logic          rst_n;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          uart_tx;
    logic          busy;
    logic [AW:0]   fifo_count;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            frames_rx = 0;
    bit            mon_en = 1'b1;
    logic [7:0]    sb [$];
    int            starts [$];

    logic [7:0]    hb [6] = '{8'h5A, 8'hC3, 8'h19, 8'hE7, 8'h42, 8'hBD};
    int            exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
    int            exp_rdy [6] = '{1, 1, 1, 1, 0, 0};

    uart_tx_unit #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (AW)
    ) dut (
        .iFpgaClk   (clk),
        .iFpgaRstN  (rst_n),
        .iTxData    (tx_data),
        .iTxValid   (tx_valid),
        .oTxReady   (tx_ready),
        .oUartTx    (uart_tx),
        .oBusy      (busy),
        .oFifoCount (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    // Line monitor: detects a start bit, samples each bit once per
    // bit period and compares the byte to the scoreboard head.
    initial begin
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic       stop_b;
        logic       par_b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n === 1'b1 && uart_tx === 1'b0) begin
                starts.push_back(cyc);
                rx = '0;
                par_b = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par_b = uart_tx;
`endif
                repeat (CPB) @(negedge clk);
                stop_b = uart_tx;
                if (mon_en) begin
                    frames_rx++;
                    chk("rx_expected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_b = sb.pop_front();
                        chk("rx_byte", {24'd0, rx}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
                        chk("rx_parity", {31'd0, par_b}, {31'd0, ^exp_b});
`endif
                    end
                    chk("rx_stop", {31'd0, stop_b}, 32'd1);
                end
            end
        end
    end

    initial begin
        logic       exp_bits [FRAME_BITS];
        logic [3:0] vec;
        logic [7:0] b;
        int         frames0;
        bit         low_seen;

        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_count", {29'd0, fifo_count}, 32'd0);

        // single byte 0xA5, full line shape
        b = 8'hA5;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^b;
`endif
        exp_bits[FRAME_BITS - 1] = 1'b1;
        tx_data  = b;
        tx_valid = 1'b1;
        sb.push_back(b);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("a5_tx_before_pop", {31'd0, uart_tx}, 32'd1);
        chk("a5_count_after_push", {29'd0, fifo_count}, 32'd1);
        for (int j = 0; j < FRAME_BITS; j++) begin
            vec = '0;
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1;
                vec[c] = uart_tx;
            end
            chk($sformatf("a5_line_bit%0d", j), {28'd0, vec},
                exp_bits[j] ? 32'hF : 32'h0);
        end
        chk("a5_busy_last_cycle", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("a5_busy_fall", {31'd0, busy}, 32'd0);
        chk("a5_count_zero", {29'd0, fifo_count}, 32'd0);
        chk("a5_tx_idle", {31'd0, uart_tx}, 32'd1);
        wait_drain(50);

        // back-to-back frames
        starts.delete();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h00; sb.push_back(8'h00);
        @(negedge clk);
        tx_data = 8'hFF; sb.push_back(8'hFF);
        @(negedge clk);
        tx_data = 8'h3C; sb.push_back(8'h3C);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain(4 * FRAME);
        chk("b2b_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            chk("b2b_gap1", 32'(starts[1] - starts[0]), 32'(FRAME));
            chk("b2b_gap2", 32'(starts[2] - starts[1]), 32'(FRAME));
        end

        // hold valid with 6 bytes, FIFO fills
        frames0 = frames_rx;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_data  = hb[i];
            tx_valid = 1'b1;
            if (i < 5) sb.push_back(hb[i]);
            @(posedge clk);
            #1;
            chk($sformatf("hold_count%0d", i), {29'd0, fifo_count},
                32'(exp_cnt[i]));
            chk($sformatf("hold_ready%0d", i), {31'd0, tx_ready},
                32'(exp_rdy[i]));
        end
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain(7 * FRAME);
        chk("hold_frames", 32'(frames_rx - frames0), 32'd5);

        // reset mid-DATA with two bytes queued
        mon_en = 1'b0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h81;
        @(negedge clk);
        tx_data = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_count", {29'd0, fifo_count}, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", {31'd0, uart_tx}, 32'd1);
        chk("async_reset_count", {29'd0, fifo_count}, 32'd0);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        frames0 = frames_rx;
        low_seen = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low_seen = 1'b1;
        end
        chk("post_reset_line_low", {31'd0, low_seen}, 32'd0);
        chk("post_reset_frames", 32'(frames_rx - frames0), 32'd0);

        // pointer wrap: 10 single bytes
        frames0 = frames_rx;
        for (int i = 0; i < 10; i++) begin
            b = 8'(i * 29 + 7);
            @(negedge clk);
            tx_data  = b;
            tx_valid = 1'b1;
            sb.push_back(b);
            @(negedge clk);
            tx_valid = 1'b0;
            wait_drain(2 * FRAME);
        end
        chk("wrap_frames", 32'(frames_rx - frames0), 32'd10);

`ifdef UART_TX_PARITY_EN
        starts.delete();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h07; sb.push_back(8'h07);
        @(negedge clk);
        tx_data = 8'h03; sb.push_back(8'h03);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain(3 * FRAME);
        chk("par_frames", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) begin
            chk("par_frame_len", 32'(starts[1] - starts[0]), 32'd44);
        end
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
- 8N1 UART transmitter: the PC-bound serial path of the Minisys CPU top, driving the board's UART-to-PC pin.
- Mirror of the coe-download receiver path; the CPU and debug logic push bytes into it.
- An internal FIFO decouples single-cycle byte writes from the slow serial line.
- Bytes are shifted LSB-first at a fixed baud derived from the FPGA clock.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, byte entries in the TX FIFO; must be a power of 2, >= 2.
- FIFO_AW, 4, log2(FIFO_DEPTH); must match FIFO_DEPTH.

Ports:
- iFpgaClk  input  1  system clock, all logic on rising edge.
- iFpgaRstN  input  1  asynchronous, active-low reset.
- iTxData  input  8  byte to transmit.
- iTxValid  input  1  push request; byte accepted on an edge where iTxValid && oTxReady.
- oTxReady  output  1  FIFO not full.
- oUartTx  output  1  serial line; idle high.
- oBusy  output  1  high while a frame is on the line or the FIFO is non-empty.
- oFifoCount  output  FIFO_AW+1  bytes currently queued (0..FIFO_DEPTH).

Behaviour:
- Reset (async assert, sync release) clears the FIFO and sets FSM=IDLE. Reset values: oUartTx=1, oTxReady=1, oBusy=0, oFifoCount=0. The baud counter and bit index are 0.
- FIFO: circular buffer with FIFO_AW-bit read/write pointers that wrap modulo FIFO_DEPTH; the count is held separately.
  - Push when iTxValid && oTxReady. Pops come from the FSM only.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - oTxReady = (count != FIFO_DEPTH), combinational from the registered count.
  - When full, iTxValid is ignored and no data is overwritten.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature). oUartTx is a registered output.
  - IDLE: if count != 0, pop the head byte into the shift register, clear the baud counter and go to START. oUartTx=0 from this edge on.
  - START: oUartTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: oUartTx = shift[bit index] for CLKS_PER_BIT cycles per bit, LSB first. After bit 7 go to STOP (or PARITY).
  - STOP: oUartTx=1 for CLKS_PER_BIT cycles. At the end, if count != 0, pop and go directly to START on the same edge (no idle gap). Otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1. A bit period ends on the edge where counter == CLKS_PER_BIT-1; the counter wraps to 0 there.
- Latency: a byte pushed at edge N into an empty FIFO, with the FSM in IDLE, is popped at edge N+1. oUartTx goes low after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles in 8N1 mode.
- oBusy = (FSM != IDLE) || (count != 0).
- iTxData is sampled only on the push edge. Later changes do not affect queued bytes.
- Reset mid-frame: the line returns high immediately, the frame is truncated, and queued bytes are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP for one bit period. It drives the even parity bit, ^data, so the total count of ones in data+parity is even. Frame length is 11*CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1, frame length 10*CLKS_PER_BIT.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset, then push 0xA5 once:
  - oUartTx low one cycle after the push edge.
  - Line sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - oBusy falls 40 cycles after the start edge; oFifoCount returns to 0.
- Push 0x00, 0xFF, 0x3C on consecutive cycles: three frames back-to-back, no idle cycle between a STOP and the next START, bytes in push order.
- Hold iTxValid high with 6 distinct bytes while the FSM is idle:
  - First pushed byte is popped on the next edge; oFifoCount reaches 4, oTxReady drops.
  - Bytes offered while not ready are not accepted and never appear on the line.
  - A push on the same edge as a pop keeps the count constant.
- Assert iFpgaRstN low mid-DATA of 0x81 with 2 bytes queued: oUartTx=1 and oFifoCount=0 asynchronously. After release, the line stays high with no further frames.
- Pointer wrap: push and drain 10 bytes one at a time (pointers wrap twice). Every byte is received intact by a bench UART monitor.
- With UART_TX_PARITY_EN defined, send 0x07 then 0x03: parity bits 1 and 0 respectively, frame length 44 cycles each.
